// File: rtl/giro_counter.sv
// Revolution counter: synchronises and debounces a raw sensor, then runs a
// start/clear counting session whose 0..9 count feeds the 7-segment stage.
module giro_counter #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       sensor_in,
    input  logic       start_in,
    input  logic       clear_in,
    input  logic [3:0] target_in,
    output logic [3:0] numgiro_out,
    output logic       giro_pulse_out,
    output logic       overflow_out,
    output logic       busy_out,
    output logic       done_out,
    output logic [1:0] state_dbg
);

    // Control is pulse based rather than valid/ready: start_in and clear_in
    // act on the single cycle they are high, with clear_in winning over start_in,
    // and start_in winning over a revolution pulse arriving in the same cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state_q;
    state_t           state_d;
    logic             sync1;
    logic             sync2;
    logic             db;
    logic             db_q;
    logic [CNT_W-1:0] stable_cnt;
    logic [3:0]       count_d;
    logic [3:0]       target_q;
    logic [3:0]       target_d;
    logic             overflow_d;
    logic             target_valid;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            db         <= 1'b0;
            db_q       <= 1'b0;
            stable_cnt <= '0;
            giro_pulse_out <= 1'b0;
        end else begin
            sync1 <= sensor_in;
            sync2 <= sync1;
            db_q  <= db;
            giro_pulse_out <= db & ~db_q;
            if (sync2 == db) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                db         <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

    // Targets outside 1..9 select free-run mode with a 9 -> 0 wrap.
    assign target_valid = (target_q != 4'd0) && (target_q <= 4'd9);

    always_comb begin
        state_d    = state_q;
        count_d    = numgiro_out;
        target_d   = target_q;
        overflow_d = 1'b0;
        if (clear_in) begin
            state_d = IDLE;
            count_d = 4'd0;
        end else if (start_in) begin
            state_d  = COUNT;
            count_d  = 4'd0;
            target_d = target_in;
        end else begin
            case (state_q)
                COUNT: begin
                    if (giro_pulse_out) begin
                        if (target_valid) begin
                            count_d = numgiro_out + 4'd1;
                            if (numgiro_out + 4'd1 == target_q) begin
                                state_d = DONE;
                            end
                        end else if (numgiro_out == 4'd9) begin
                            count_d    = 4'd0;
                            overflow_d = 1'b1;
                        end else begin
                            count_d = numgiro_out + 4'd1;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q      <= IDLE;
            numgiro_out  <= 4'd0;
            target_q     <= 4'd0;
            overflow_out <= 1'b0;
        end else begin
            state_q      <= state_d;
            numgiro_out  <= count_d;
            target_q     <= target_d;
            overflow_out <= overflow_d;
        end
    end

    assign busy_out  = (state_q == COUNT);
    assign done_out  = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
